// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared operation encodings, latency defaults and result type
//               for the EXE-stage HI/LO multiply-divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t c_op_none  = 3'd0;
  localparam op_t c_op_mult  = 3'd1;
  localparam op_t c_op_multu = 3'd2;
  localparam op_t c_op_div   = 3'd3;
  localparam op_t c_op_divu  = 3'd4;
  localparam op_t c_op_mthi  = 3'd5;
  localparam op_t c_op_mtlo  = 3'd6;

  localparam int c_mult_cycles_def = 5;
  localparam int c_div_cycles_def  = 10;

  // 64-bit result split the way it lands in the architectural registers
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational 32x32 multiply / divide datapath producing the
//               64-bit {hi,lo} result, including sign and divide-by-zero rules.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output hilo_t       result
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_is_signed;
  logic               w_div_by_zero;
  logic               w_neg_a;
  logic               w_neg_b;
  logic        [31:0] w_mag_a;
  logic        [31:0] w_mag_b;
  logic        [31:0] w_divisor;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;
  logic        [31:0] w_quot;
  logic        [31:0] w_rem;

  // Full-width products; the signed one works on sign-extended operands
  assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps cleanly
  // to 0x80000000 instead of relying on overflow behaviour of signed '/'.
  assign w_is_signed   = (op == c_op_div);
  assign w_div_by_zero = (rt_val == 32'd0);
  assign w_neg_a       = w_is_signed & rs_val[31];
  assign w_neg_b       = w_is_signed & rt_val[31];
  assign w_mag_a       = w_neg_a ? (~rs_val + 32'd1) : rs_val;
  assign w_mag_b       = w_neg_b ? (~rt_val + 32'd1) : rt_val;
  // Divisor forced to 1 on zero so the divider never sees /0
  assign w_divisor     = w_div_by_zero ? 32'd1 : w_mag_b;
  assign w_uquot       = w_mag_a / w_divisor;
  assign w_urem        = w_mag_a % w_divisor;
  assign w_quot        = (w_neg_a ^ w_neg_b) ? (~w_uquot + 32'd1) : w_uquot;
  assign w_rem         = w_neg_a ? (~w_urem + 32'd1) : w_urem;

  // Select the result for the requested operation
  always_comb begin
    result = '0;
    case (op)
      c_op_mult:  result = w_prod_s;
      c_op_multu: result = w_prod_u;
      c_op_div, c_op_divu: begin
        if (w_div_by_zero) begin
          result.hi = rs_val;
          result.lo = 32'hFFFF_FFFF;
        end else begin
          result.hi = w_rem;
          result.lo = w_quot;
        end
      end
      default:    result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : EXE-stage HI/LO multiply-divide unit. Captures operands on a
//               mult/div start, holds busy for a fixed latency, then commits
//               the pending result to the architectural HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = c_mult_cycles_def,
  parameter int DIV_CYCLES  = c_div_cycles_def
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // DIV_CYCLES is the larger latency, so it sizes the counter
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_count, w_count;
  hilo_t            r_pend,  w_pend;
  logic [31:0]      r_hi,    w_hi;
  logic [31:0]      r_lo,    w_lo;
  logic             r_busy,  w_busy;
  hilo_t            w_result;

  mdu_arith u_arith (
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .result (w_result)
  );

  // State, counter, pending result and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_pend  <= w_pend;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_busy  <= w_busy;
    end
  end

  // Next-state logic: accept ops only in IDLE, count down and commit in RUN
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_pend  = r_pend;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_busy  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            c_op_mult, c_op_multu: begin
              w_pend  = w_result;
              w_count = c_mult_cnt;
              w_busy  = 1'b1;
              w_state = ST_RUN;
            end
            c_op_div, c_op_divu: begin
              w_pend  = w_result;
              w_count = c_div_cnt;
              w_busy  = 1'b1;
              w_state = ST_RUN;
            end
            c_op_mthi: w_hi = rs_val;
            c_op_mtlo: w_lo = rs_val;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A start seen here is a hazard-unit escape and is dropped
        if (r_count == c_cnt_one) begin
          w_hi    = r_pend.hi;
          w_lo    = r_pend.lo;
          w_count = '0;
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else if (r_count == '0) begin
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end else begin
          w_count = r_count - c_cnt_one;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_count = '0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit: directed cases with
//               literal expectations plus randomized traffic compared every
//               cycle against a timestamp-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the ISA rules, using 64-bit math
  function automatic logic [63:0] ref_result(input op_t o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      c_op_mult:  res = 64'(sa * sb);
      c_op_multu: res = {32'd0, a} * {32'd0, b};
      c_op_div: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      c_op_divu: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Behavioural model: a pending result lands at a known absolute edge number
  int          edge_n = 0;
  int          m_commit = 0;
  logic        m_pend = 1'b0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      edge_n++;
      if (m_pend) begin
        if (edge_n == m_commit) begin
          m_hi   = m_res[63:32];
          m_lo   = m_res[31:0];
          m_pend = 1'b0;
        end
      end else if (start) begin
        if (op == c_op_mult || op == c_op_multu) begin
          m_res = ref_result(op, rs_val, rt_val);
          m_commit = edge_n + MULT_N;
          m_pend = 1'b1;
        end else if (op == c_op_div || op == c_op_divu) begin
          m_res = ref_result(op, rs_val, rt_val);
          m_commit = edge_n + DIV_N;
          m_pend = 1'b1;
        end else if (op == c_op_mthi) begin
          m_hi = rs_val;
        end else if (op == c_op_mtlo) begin
          m_lo = rs_val;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_pend});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  task automatic issue(input op_t o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    // Scramble operands afterwards: the result must use the captured values
    start  = 1'b0;
    op     = c_op_none;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Count busy cycles while checking HI/LO hold; optionally inject a stray start
  task automatic run_busy(input int inject, input string tag, output int cnt);
    logic [31:0] oh, ol;
    oh = hi;
    ol = lo;
    cnt = 0;
    while (busy && cnt < 40) begin
      chk({tag, "_hold_hi"}, hi, oh);
      chk({tag, "_hold_lo"}, lo, ol);
      if (inject > 0 && cnt == inject) begin
        start  = 1'b1;
        op     = c_op_mult;
        rs_val = 32'd2;
        rt_val = 32'd3;
      end else begin
        start  = 1'b0;
        op     = c_op_none;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    op    = c_op_none;
  endtask

  task automatic do_op(input op_t o, input logic [31:0] a, input logic [31:0] b,
                       input int n_exp, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input string tag, input int inject);
    int cnt;
    issue(o, a, b);
    run_busy(inject, tag, cnt);
    chk({tag, "_cycles"}, 32'(cnt), 32'(n_exp));
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset  = 1'b0;
    start  = 1'b0;
    op     = c_op_none;
    rs_val = '0;
    rt_val = '0;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results
    do_op(c_op_mult,  32'hFFFF_FFFD, 32'd5,         MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0);
    do_op(c_op_multu, 32'hFFFF_FFFF, 32'd2,         MULT_N, 32'h0000_0001, 32'hFFFF_FFFE, "multu", 0);
    do_op(c_op_div,   32'hFFFF_FFF9, 32'd2,         DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
    do_op(c_op_divu,  32'd7,         32'd0,         DIV_N,  32'h0000_0007, 32'hFFFF_FFFF, "divu_zero", 0);
    do_op(c_op_div,   32'h8000_0000, 32'hFFFF_FFFF, DIV_N,  32'h0000_0000, 32'h8000_0000, "div_ovf", 0);
    do_op(c_op_mthi,  32'h1234_5678, 32'd0,         0,      32'h1234_5678, 32'h8000_0000, "mthi", 0);
    do_op(c_op_mtlo,  32'hA5A5_A5A5, 32'd0,         0,      32'h1234_5678, 32'hA5A5_A5A5, "mtlo", 0);
    do_op(c_op_div,   32'd100,       32'd7,         DIV_N,  32'd2,         32'd14,        "div_inject", 3);

    // Randomized traffic, including starts while busy
    for (int i = 0; i < 400; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 6));
      rs_val = pick();
      rt_val = pick();
      @(negedge clk);
    end
    start = 1'b0;
    op    = c_op_none;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rand_drain", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    do_op(c_op_mthi, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, lo, "pre_rst_hi", 0);
    do_op(c_op_mtlo, 32'h0BAD_F00D, 32'd0, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, "pre_rst_lo", 0);
    issue(c_op_mult, 32'd3, 32'd3);
    @(negedge clk);
    chk("rst_run_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MULT_N + 3) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
